// File: rtl/jtframe_pocket_dlseq_pkg.sv
// jtframe_pocket_dlseq_pkg: shared constants, FSM encoding and byte-select helper
// for the Pocket bridge download sequencer.
package jtframe_pocket_dlseq_pkg;

   // Bridge command space prefix: writes here never reach the download path
   localparam logic [7:0] CMD_PREFIX = 8'hF8;
   // FIFO entry: {byte address[24:0], word data[31:0]}
   localparam int WORD_W = 57;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   // Byte c of word d; big-endian order starts from the top byte
   function automatic logic [7:0] sel_byte(input logic [31:0] d, input logic [1:0] c, input logic be);
      logic [1:0] i;
      i = be ? ~c : c;
      return d[{i, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/jtframe_pocket_dlfifo.sv
// jtframe_pocket_dlfifo: word FIFO between the bridge and the byte sequencer.
// Ports: clk/rst (async active-high), push/din write side, pop/dout read side
// (dout shows the head entry combinationally), full/empty status.
module jtframe_pocket_dlfifo
   import jtframe_pocket_dlseq_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [WORD_W-1:0] din,
   input  logic              pop,
   output logic [WORD_W-1:0] dout,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   logic [AW:0]       wp, rp;
   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp[AW-1:0]] <= din;
   end

   assign dout  = mem[rp[AW-1:0]];
   assign empty = wp == rp;
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/jtframe_pocket_dlseq.sv
// jtframe_pocket_dlseq: turns bridge word writes into ioctl byte writes.
// Ports: clk, rst (async active-high); wr/wr_addr/wr_data bridge word writes;
// ds_done end-of-download hint; prog_rdy SDRAM ack of the last byte;
// ioctl_addr/ioctl_dout/ioctl_wr byte stream; downloading session flag;
// ovf sticky word-drop flag.
module jtframe_pocket_dlseq
   import jtframe_pocket_dlseq_pkg::*;
#(
   parameter int   DEPTH      = 4,
   parameter logic BIG_ENDIAN = 1'b0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   input  logic        ds_done,
   input  logic        prog_rdy,
   output logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_dout,
   output logic        ioctl_wr,
   output logic        downloading,
   output logic        ovf
);
   state_t            state, state_n;
   logic              cmd, push, pop, full, empty, pending, clr, last;
   logic [WORD_W-1:0] fifo_q, word, word_n;
   logic [1:0]        cnt, cnt_n;

   assign cmd  = wr_addr[31:24] == CMD_PREFIX;
   // A full FIFO still accepts a word when the head leaves in the same cycle
   assign push = wr && !cmd && (!full || pop);
   assign last = cnt == 2'd3;
   // Session ends only once every queued word has been emitted
   assign clr  = pending && state == ST_IDLE && empty;

   jtframe_pocket_dlfifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({wr_addr[24:0], wr_data}),
      .pop   (pop),
      .dout  (fifo_q),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  state_n = empty ? ST_IDLE : ST_LOAD;
         ST_LOAD:  state_n = ST_WRITE;
         ST_WRITE: state_n = ST_WAIT;
         ST_WAIT:  state_n = !prog_rdy ? ST_WAIT : !last ? ST_WRITE : !empty ? ST_LOAD : ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      ioctl_wr = state == ST_WRITE;
      pop      = state == ST_LOAD;
   end

   // Next word/counter values let the byte outputs be registered on entry to WRITE
   always_comb begin
      word_n = pop ? fifo_q : word;
      cnt_n  = pop ? 2'd0 : (state == ST_WAIT && prog_rdy && !last) ? cnt + 2'd1 : cnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word        <= '0;
         cnt         <= '0;
         ioctl_addr  <= '0;
         ioctl_dout  <= '0;
         downloading <= 1'b0;
         pending     <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         word <= word_n;
         cnt  <= cnt_n;
         if (state_n == ST_WRITE) begin
            ioctl_addr <= (word_n[56:32] & ~25'd3) | {23'd0, cnt_n};
            ioctl_dout <= sel_byte(word_n[31:0], cnt_n, BIG_ENDIAN);
         end
         downloading <= push ? 1'b1 : clr ? 1'b0 : downloading;
         pending     <= clr ? 1'b0 : (ds_done && (downloading || push)) ? 1'b1 : pending;
         if (wr && !cmd && full && !pop) ovf <= 1'b1;
      end
   end

endmodule
